// File: rtl/div_pkg.sv
// Shared constants for the sequential divider: default operand width and FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_pkg;

    // Default operand/result width of the divider.
    localparam int DIV_WIDTH = 5;

    // FSM state encoding, kept as plain constants so older tools can consume it.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/div5_seq_sub_cla.sv
// sub_cla: W-bit carry-lookahead subtractor, diff = a + ~b + 1, borrow_out = ~carry_out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result follows the inputs every cycle.
// Ports: a, b (W-bit operands), diff (W-bit difference), borrow_out (1 when a < b).
module sub_cla #(
    parameter int W = 6
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow_out
);

    logic [W-1:0] gen;
    logic [W-1:0] prop;
    logic [W:0]   carry;

    assign gen  = a & ~b;
    assign prop = a ^ ~b;

    // Each carry is formed directly from the generate/propagate terms of all
    // lower bits plus the carry-in of 1, rather than rippling bit by bit.
    always_comb begin
        logic acc;
        logic pp;
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < W; i++) begin
            acc = gen[i];
            pp  = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & gen[j]);
                pp  = pp & prop[j];
            end
            carry[i+1] = acc | (pp & carry[0]);
        end
    end

    assign diff       = prop ^ carry[W-1:0];
    assign borrow_out = ~carry[W];

endmodule

// File: rtl/div5_seq.sv
// div5_seq: unsigned restoring divider, one quotient bit per cycle (IDLE -> CALC -> DONE).
// Latency: done pulses WIDTH+1 cycles after start is sampled (1 cycle for a zero divisor
//          when DIV5_SEQ_ZERO_DETECT_EN is defined).
// Backpressure: start is only accepted in IDLE or DONE; start during CALC is dropped.
// Ports: clk, rst (sync, active-high), start/dividend/divisor (request), busy (in CALC),
//        done (1-cycle result pulse), quotient/remainder (held until next done),
//        div_by_zero (only driven when DIV5_SEQ_ZERO_DETECT_EN is defined, else 0).
module div5_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend, shifted left as its MSBs are consumed
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] prem_q, prem_d;   // partial remainder
    logic [WIDTH-1:0] qacc_q, qacc_d;   // quotient bits accumulated so far
    logic [CNT_W-1:0] cnt_q, cnt_d;     // iterations left
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
`ifdef DIV5_SEQ_ZERO_DETECT_EN
    logic             dbz_q, dbz_d;
`endif

    // One restoring step: trial-subtract the divisor from {partial rem, next bit}.
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   sub_diff;
    logic             sub_borrow;
    logic [WIDTH-1:0] prem_next;
    logic [WIDTH-1:0] qacc_next;
    logic             unused_diff_msb;

    assign trial = {prem_q, dvd_q[WIDTH-1]};

    sub_cla #(.W(WIDTH + 1)) u_sub_cla (
        .a          (trial),
        .b          ({1'b0, dvs_q}),
        .diff       (sub_diff),
        .borrow_out (sub_borrow)
    );

    // Without a borrow the difference is below the divisor, so its MSB is always 0.
    assign unused_diff_msb = sub_diff[WIDTH];
    assign prem_next       = sub_borrow ? trial[WIDTH-1:0] : sub_diff[WIDTH-1:0];
    assign qacc_next       = (qacc_q << 1) | {{(WIDTH-1){1'b0}}, ~sub_borrow};

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        qacc_d  = qacc_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
`ifdef DIV5_SEQ_ZERO_DETECT_EN
        dbz_d   = dbz_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    prem_d  = '0;
                    qacc_d  = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = S_CALC;
`ifdef DIV5_SEQ_ZERO_DETECT_EN
                    // Zero divisor short-circuits straight to the result.
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                dvd_d  = dvd_q << 1;
                prem_d = prem_next;
                qacc_d = qacc_next;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    quo_d   = qacc_next;
                    rem_d   = prem_next;
`ifdef DIV5_SEQ_ZERO_DETECT_EN
                    dbz_d   = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            qacc_q  <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
`ifdef DIV5_SEQ_ZERO_DETECT_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            qacc_q  <= qacc_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
`ifdef DIV5_SEQ_ZERO_DETECT_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign busy      = (state_q == S_CALC);
    assign done      = (state_q == S_DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
`ifdef DIV5_SEQ_ZERO_DETECT_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div5_seq.sv
// Testbench for div5_seq: directed and random operations against a scoreboard.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_div5_seq;

    localparam int W = 5;
`ifdef DIV5_SEQ_ZERO_DETECT_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    div5_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           done_cyc;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           last_done = -1;
    int           checks = 0;
    int           errors = 0;
    bit           mon_en = 1'b0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    logic         last_dbz = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division; a zero divisor yields all ones and the
    // dividend, finishing early only when zero detection is built in.
    function automatic exp_t model(input int a, input int b, input int s);
        exp_t e;
        int   lat;
        if (b == 0) begin
            e.q   = '1;
            e.r   = W'(a);
            e.dbz = ZD;
            lat   = ZD ? 1 : W + 1;
        end else begin
            e.q   = W'(a / b);
            e.r   = W'(a % b);
            e.dbz = 1'b0;
            lat   = W + 1;
        end
        e.done_cyc = s + lat - 1;
        return e;
    endfunction

    // Drive start for one sampling edge; the request is accepted only if the
    // previous operation had reached its done cycle (or the DUT was idle).
    task automatic issue(input int a, input int b);
        int   c;
        exp_t e;
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        @(posedge clk);
        #1;
        c     = cyc;
        start = 1'b0;
        if (c - 1 >= last_done) begin
            e = model(a, b, c);
            sb.push_back(e);
            last_done = e.done_cyc;
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic after_reset();
        sb.delete();
        last_done = cyc;
        last_q    = '0;
        last_r    = '0;
        last_dbz  = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_div_by_zero", div_by_zero, 0);
    endtask

    // Monitor: compares busy/done every cycle, results on done, and holding otherwise.
    always @(negedge clk) begin
        bit   ed;
        bit   eb;
        exp_t e;
        if (mon_en && !rst) begin
            ed = (sb.size() > 0) && (cyc == sb[0].done_cyc);
            eb = (sb.size() > 0) && (cyc < sb[0].done_cyc);
            chk("busy", busy, eb);
            chk("done", done, ed);
            if (ed) begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", div_by_zero, e.dbz);
                last_q   = e.q;
                last_r   = e.r;
                last_dbz = e.dbz;
            end else begin
                chk("hold_quotient", quotient, last_q);
                chk("hold_remainder", remainder, last_r);
                chk("hold_div_by_zero", div_by_zero, last_dbz);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int a;
        int b;
        int g;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        after_reset();
        mon_en = 1'b1;

        issue(23, 5);
        wait_cyc(last_done + 1);
        issue(31, 1);
        wait_cyc(last_done + 1);
        issue(4, 9);
        wait_cyc(last_done + 1);
        issue(7, 0);
        wait_cyc(last_done + 1);

        // Second start while calculating must be dropped.
        issue(20, 3);
        s = cyc;
        wait_cyc(s + 2);
        issue(9, 2);
        wait_cyc(last_done + 1);

        // Reset in the middle of an operation.
        issue(20, 3);
        s = cyc;
        wait_cyc(s + 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        after_reset();
        issue(9, 2);

        // Back-to-back: start sampled during the DONE cycle.
        wait_cyc(last_done);
        issue(13, 4);
        wait_cyc(last_done);
        issue(30, 7);
        wait_cyc(last_done + 1);

        for (int i = 0; i < 40; i++) begin
            g = $urandom_range(0, 3);
            wait_cyc(last_done + g);
            a = $urandom_range(0, 31);
            b = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 31);
            issue(a, b);
            if ($urandom_range(0, 4) == 0) begin
                wait_cyc(cyc + $urandom_range(0, 2));
                issue($urandom_range(0, 31), $urandom_range(1, 31));
            end
        end

        wait_cyc(last_done + 2);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div5_seq.md
DIV5_SEQ -- requirements
Module: div5_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 5, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE or DONE.
REQ-005 SHALL have port dividend  input  WIDTH  unsigned numerator, captured with start.
REQ-006 SHALL have port divisor  input  WIDTH  unsigned denominator, captured with start.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-009 SHALL have port quotient  output  WIDTH  registered quotient.
REQ-010 SHALL have port remainder  output  WIDTH  registered remainder.
REQ-011 SHALL have port div_by_zero  output  1  registered flag; divisor was zero.

Function
REQ-012 SHALL implement an unsigned restoring divider with FSM states IDLE, CALC, DONE.
REQ-013 SHALL, when start=1 in IDLE or DONE, capture the operands, clear the partial remainder, load the iteration count, and enter CALC.
REQ-014 SHALL ignore start while in CALC; the operation in flight is unaffected.
REQ-015 SHALL perform one iteration per CALC cycle:
- t = {partial remainder, next dividend MSB}, WIDTH+1 bits.
- Compute t minus the zero-extended divisor.
- No borrow: remainder = difference, quotient bit = 1.
- Borrow: remainder = t[WIDTH-1:0], quotient bit = 0.
REQ-016 SHALL leave CALC for DONE after exactly WIDTH iterations.
REQ-017 SHALL assert done in cycle WIDTH+1, counting the start-sample cycle as 0.
REQ-018 SHALL drive busy=1 in CALC only, and done=1 in DONE only.
REQ-019 SHALL go from DONE to IDLE after one cycle unless start=1.
REQ-020 SHALL update quotient and remainder only on the DONE transition, and hold them until the next DONE.
REQ-021 SHALL produce results satisfying dividend = quotient*divisor + remainder, with remainder < divisor, for divisor != 0.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, force IDLE with busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and internal registers cleared.
REQ-023 SHALL abort any operation in CALC on reset without producing done.
REQ-024 SHALL give rst priority over start in the same cycle.

Configuration
REQ-025 SHALL support macro DIV5_SEQ_ZERO_DETECT_EN.
REQ-026 SHALL, with the macro defined and divisor=0 at start:
- Go directly to DONE, so done appears in cycle 1.
- Set quotient = all ones, remainder = dividend, div_by_zero=1.
REQ-027 SHALL, with the macro defined and divisor != 0, set div_by_zero=0 at DONE.
REQ-028 SHALL, without the macro:
- Run the full WIDTH iterations for divisor=0, giving quotient = all ones, remainder = dividend.
- Tie div_by_zero to 0.

Structure
REQ-029 SHALL take FSM state encoding (IDLE/CALC/DONE) and the WIDTH default from shared package div_pkg.
REQ-030 SHALL instantiate exactly one sub-module, sub_cla, a WIDTH+1-bit carry-lookahead subtractor.
REQ-031 SHALL have sub_cla compute a + ~b + 1 and output the difference and borrow_out.

Verification
REQ-032 SHALL cover: start with 23/5 -> done in cycle 6, quotient=4, remainder=3, div_by_zero=0.
REQ-033 SHALL cover: start with 31/1 -> quotient=31, remainder=0; then 4/9 -> quotient=0, remainder=4.
REQ-034 SHALL cover: start with 7/0 ->
- Macro on: done in cycle 1, quotient=31, remainder=7, div_by_zero=1.
- Macro off: done in cycle 6, quotient=31, remainder=7, div_by_zero=0.
REQ-035 SHALL cover: start 20/3 then start 9/2 in cycle 3 -> the second start is ignored; done in cycle 6 with quotient=6, remainder=2.
REQ-036 SHALL cover: start 20/3 then rst in cycle 3 -> no done, all outputs 0; then start 9/2 -> quotient=4, remainder=1.
REQ-037 SHALL cover: start held high during a DONE cycle -> back-to-back operation accepted, with the next done 6 cycles later.
